toggle_event_gen: RTL and testbench
===================================

Name: toggle_event_gen

Overview:
- Upstream stage of the per-signal toggle-coverage reporter.
- Samples a monitored signal vector every clock and detects per-bit transitions.
- Emits a one-cycle per-bit valid pulse when a bit completes a full toggle (a rise and a fall, in either order); that vector drives the reporter's valid input.
- Also keeps a running count of covered bits for on-chip status and formal cover properties.

Parameters:
WIDTH, 5, number of monitored bits; equals the downstream reporter's valid width.
CNT_W, $clog2(WIDTH+1), width of covered_cnt (6 is legal for WIDTH=5: 3 bits minimum).

Ports:
clock  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
en  input  1  sampling enable; when 0 no flags, history or outputs advance except valid clearing.
clear  input  1  synchronous clear of per-bit coverage state and counter.
sig  input  WIDTH  monitored signal vector.
valid  output  WIDTH  registered one-cycle toggle-complete pulse per bit.
covered_cnt  output  CNT_W  number of bits that have pulsed at least once since reset/clear.
all_covered  output  1  registered; 1 when covered_cnt == WIDTH.

Behaviour:
- Per-bit state: prev (last sample), primed (prev valid), rise_seen, fall_seen, done.
- Reset (reset=0):
  - all state cleared.
  - valid=0, covered_cnt=0, all_covered=0.
- Priming:
  - first enabled edge after reset or clear loads prev=sig and sets primed.
  - no edge is evaluated on that sample, so a reset-time value never counts as a transition.
- Edge detection at an enabled edge with primed=1:
  - rise = ~prev & sig; fall = prev & ~sig.
  - prev <= sig.
- Per-bit flag update:
  - rise_seen |= rise; fall_seen |= fall.
- Completion: a bit completes when, after the update, rise_seen & fall_seen is 1 and done=0.
  - valid[i] <= 1 for exactly one cycle, visible in the cycle after the completing edge (latency 1).
  - rise_seen and fall_seen clear in the same edge.
  - if done was 0, done sets and covered_cnt increments.
  - multiple bits completing on the same edge each pulse; covered_cnt adds their popcount in one step.
- valid is 0 on every edge without a completion, including en=0 edges, so no pulse is ever stretched.
- en=0: prev, primed and flags hold. Toggles while disabled are not seen; on re-enable, sig is compared against the held prev.
- clear=1 (synchronous, overrides en):
  - primed, flags, done and covered_cnt go to 0; valid goes to 0.
  - prev is reloaded on the next enabled edge.
  - a completion on the same edge as clear is discarded.
- covered_cnt saturates at WIDTH; it can never exceed WIDTH and never wraps.
- all_covered follows covered_cnt with the same registration (updates on the same edge).
- Reset asserted mid-operation: all outputs drop to 0 asynchronously; no pulse is emitted on release.

Optional Feature:
- Macro: TOGGLE_GEN_STICKY_EN.
- Defined: after a bit's first completion (done=1), its valid never pulses again until reset or clear; flags still track, but completions are suppressed.
- Undefined: each subsequent complete rise+fall pair pulses valid again; covered_cnt still counts only first completions.

Test Plan:
- Reset release with sig=5'b10101, en=1, sig held constant 20 cycles -> valid stays 0, covered_cnt=0 (priming never reports an edge).
- After priming, sig[0] 0->1 at edge k, 1->0 at edge k+3 -> valid=5'b00001 only in the cycle after edge k+3; covered_cnt=1.
- All bits rise together, then all fall together -> valid=5'b11111 for one cycle, covered_cnt 0->5 in one step, all_covered=1 on the same cycle.
- sig[2] toggles twice fully (4 transitions) ->
  - STICKY defined: one pulse total.
  - STICKY undefined: two pulses.
  - covered_cnt=1 in both builds.
- Complete a toggle of sig[1], then en=0 while sig[1] toggles 0->1->0, then en=1 -> no pulse for the disabled toggles; flags unchanged.
- clear=1 on the same edge a toggle of sig[3] completes -> no pulse, covered_cnt=0; next enabled edge reprimes; reset_n=0 mid-stream drops all outputs immediately.

Source files
------------

// File: rtl/toggle_event_gen.sv
// Per-bit toggle detector: pulses valid[i] for one cycle when bit i completes a rise+fall pair.
// Latency: 1 cycle from the completing edge. No backpressure; en=0 freezes history.
// Define TOGGLE_GEN_STICKY_EN to suppress repeat pulses after a bit's first completion.
module toggle_event_gen #(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] valid,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] primed;
  logic [WIDTH-1:0] rise_seen;
  logic [WIDTH-1:0] fall_seen;
  logic [WIDTH-1:0] done;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_upd;
  logic [WIDTH-1:0] fall_upd;
  logic [WIDTH-1:0] complete;
  logic [WIDTH-1:0] first_done;
  logic [CNT_W:0]   inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    // Unprimed bits report no edges, so the priming sample shares the normal update path.
    rise     = primed & ~prev & sig;
    fall     = primed & prev & ~sig;
    rise_upd = rise_seen | rise;
    fall_upd = fall_seen | fall;
`ifdef TOGGLE_GEN_STICKY_EN
    complete = rise_upd & fall_upd & ~done;
`else
    complete = rise_upd & fall_upd;
`endif
    first_done = complete & ~done;

    inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc = inc + (CNT_W + 1)'(first_done[i]);
    end
    sum = {1'b0, covered_cnt} + inc;
    if (sum > (CNT_W + 1)'(WIDTH)) begin
      cnt_nxt = CNT_W'(WIDTH);
    end else begin
      cnt_nxt = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev        <= '0;
      primed      <= '0;
      rise_seen   <= '0;
      fall_seen   <= '0;
      done        <= '0;
      valid       <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else if (clear) begin
      // prev is left alone; it is reloaded by the next enabled (priming) edge.
      primed      <= '0;
      rise_seen   <= '0;
      fall_seen   <= '0;
      done        <= '0;
      valid       <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else if (en) begin
      prev        <= sig;
      primed      <= '1;
      rise_seen   <= rise_upd & ~complete;
      fall_seen   <= fall_upd & ~complete;
      done        <= done | complete;
      valid       <= complete;
      covered_cnt <= cnt_nxt;
      all_covered <= (cnt_nxt == CNT_W'(WIDTH));
    end else begin
      valid <= '0;
    end
  end

endmodule

// File: tb/tb_toggle_event_gen.sv
// Directed bench for toggle_event_gen; expectations adapt to TOGGLE_GEN_STICKY_EN.
module tb_toggle_event_gen;

  localparam int WIDTH = 5;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef TOGGLE_GEN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clock;
  logic             reset;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  int n_checks = 0;
  int n_fail   = 0;

  toggle_event_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    clear = 1'b0;
    sig   = 5'b10101;

    // Reset state
    #3;
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_cnt", 32'(covered_cnt), 32'h0);
    chk("rst_all", 32'(all_covered), 32'h0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;

    // Constant sig after release: priming must not report edges
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("prime_const_valid", 32'(valid), 32'h0);
    end
    chk("prime_const_cnt", 32'(covered_cnt), 32'h0);

    // Single bit 0 toggle: rise at k, fall at k+3
    sig = 5'b00000; clear = 1'b1;
    tick();
    chk("t2_clear_valid", 32'(valid), 32'h0);
    clear = 1'b0;
    tick();
    chk("t2_prime_valid", 32'(valid), 32'h0);
    sig = 5'b00001;
    tick();
    chk("t2_rise_valid", 32'(valid), 32'h0);
    tick();
    tick();
    chk("t2_hold_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t2_pulse", 32'(valid), 32'h01);
    chk("t2_cnt", 32'(covered_cnt), 32'h1);
    chk("t2_all", 32'(all_covered), 32'h0);
    tick();
    chk("t2_one_cycle", 32'(valid), 32'h0);

    // All bits rise then fall together
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    sig = 5'b11111;
    tick();
    chk("t3_rise_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t3_pulse", 32'(valid), 32'h1f);
    chk("t3_cnt", 32'(covered_cnt), 32'h5);
    chk("t3_all", 32'(all_covered), 32'h1);
    tick();
    chk("t3_one_cycle", 32'(valid), 32'h0);
    sig = 5'b11111;
    tick();
    sig = 5'b00000;
    tick();
    chk("t3_repeat_pulse", 32'(valid), STICKY ? 32'h0 : 32'h1f);
    chk("t3_cnt_sat", 32'(covered_cnt), 32'h5);
    chk("t3_all_hold", 32'(all_covered), 32'h1);

    // sig[2] toggles twice
    clear = 1'b1;
    tick();
    chk("t4_clear_all", 32'(all_covered), 32'h0);
    clear = 1'b0;
    tick();
    sig = 5'b00100;
    tick();
    sig = 5'b00000;
    tick();
    chk("t4_first_pulse", 32'(valid), 32'h04);
    chk("t4_cnt1", 32'(covered_cnt), 32'h1);
    sig = 5'b00100;
    tick();
    chk("t4_mid_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t4_second_pulse", 32'(valid), STICKY ? 32'h0 : 32'h04);
    chk("t4_cnt2", 32'(covered_cnt), 32'h1);

    // sig[1] completes, then toggles while disabled
    sig = 5'b00010;
    tick();
    sig = 5'b00000;
    tick();
    chk("t5_pulse", 32'(valid), 32'h02);
    chk("t5_cnt", 32'(covered_cnt), 32'h2);
    en = 1'b0;
    sig = 5'b00010;
    tick();
    chk("t5_dis_clear_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t5_dis_valid", 32'(valid), 32'h0);
    en = 1'b1;
    tick();
    chk("t5_reen_valid", 32'(valid), 32'h0);
    sig = 5'b00010;
    tick();
    chk("t5_no_stale_flags", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t5_next_pair", 32'(valid), STICKY ? 32'h0 : 32'h02);
    // Rise while disabled must be seen against held prev on re-enable
    en = 1'b0;
    sig = 5'b00010;
    tick();
    en = 1'b1;
    tick();
    chk("t5_held_prev_rise", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t5_held_prev_pair", 32'(valid), STICKY ? 32'h0 : 32'h02);
    chk("t5_cnt_final", 32'(covered_cnt), 32'h2);

    // clear on the completing edge of sig[3]
    sig = 5'b01000;
    tick();
    chk("t6_rise_valid", 32'(valid), 32'h0);
    sig = 5'b00000; clear = 1'b1;
    tick();
    chk("t6_clear_valid", 32'(valid), 32'h0);
    chk("t6_clear_cnt", 32'(covered_cnt), 32'h0);
    clear = 1'b0;
    sig = 5'b01000;
    tick();
    chk("t6_reprime_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t6_fall_only", 32'(valid), 32'h0);
    sig = 5'b01000;
    tick();
    chk("t6_pulse", 32'(valid), 32'h08);
    chk("t6_cnt", 32'(covered_cnt), 32'h1);

    // Asynchronous reset mid-stream
    #2;
    reset = 1'b0;
    #1;
    chk("t7_async_valid", 32'(valid), 32'h0);
    chk("t7_async_cnt", 32'(covered_cnt), 32'h0);
    chk("t7_async_all", 32'(all_covered), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("t7_release_valid", 32'(valid), 32'h0);
    sig = 5'b00000;
    tick();
    chk("t7_fall_valid", 32'(valid), 32'h0);
    sig = 5'b01000;
    tick();
    chk("t7_pulse", 32'(valid), 32'h08);
    chk("t7_cnt", 32'(covered_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
